// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and default timing constants for the video
//                timing generator and its pattern sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Horizontal mode defaults (active / total pixels per line)
    localparam int c_H40_ACT = 320;
    localparam int c_H40_TOT = 420;
    localparam int c_H32_ACT = 256;
    localparam int c_H32_TOT = 342;
    localparam int c_H_FP    = 14;
    localparam int c_H_SYNC  = 32;

    // Vertical defaults (lines)
    localparam int c_V_ACT   = 224;
    localparam int c_V_TOT   = 262;
    localparam int c_V_FP    = 3;
    localparam int c_V_SYNC  = 3;

    // Test pattern selector
    typedef enum logic [1:0] {
        PAT_BARS   = 2'd0,
        PAT_STRIPE = 2'd1,
        PAT_GRAD   = 2'd2,
        PAT_GRID   = 2'd3
    } pattern_e;

    // One 24-bit pixel
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam rgb24_t c_RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb24_t c_RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb24_t c_RGB_GREY  = '{r: 8'h20, g: 8'h20, b: 8'h20};

    // Eight equal colour bars span the active width.
    function automatic int bar_width(input int hact);
        return hact / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern
//  Description : Combinational test-pattern colour for the pixel addressed by
//                the timing counters. Blanking is applied by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern
    import video_pkg::*;
(
    input  pattern_e   i_pat,
    input  logic [7:0] i_hlow,     // hcount[7:0]
    input  logic [3:0] i_vlow,     // vcount[3:0]
    input  logic [2:0] i_bar_idx,  // current colour bar, tracked by the parent
    output rgb24_t     o_rgb
);

    // Select the colour for the addressed pixel from the latched pattern.
    always_comb begin
        o_rgb = c_RGB_BLACK;
        case (i_pat)
            PAT_BARS: begin
                // White, yellow, cyan, green, magenta, red, blue, black
                o_rgb.r = i_bar_idx[1] ? 8'h00 : 8'hFF;
                o_rgb.g = i_bar_idx[2] ? 8'h00 : 8'hFF;
                o_rgb.b = i_bar_idx[0] ? 8'h00 : 8'hFF;
            end
            PAT_STRIPE: o_rgb = i_hlow[0] ? c_RGB_BLACK : c_RGB_WHITE;
            PAT_GRAD:   o_rgb.r = i_hlow;
            PAT_GRID:   o_rgb = ((i_hlow[3:0] == 4'd0) || (i_vlow == 4'd0)) ?
                                c_RGB_WHITE : c_RGB_GREY;
            default:    o_rgb = c_RGB_BLACK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Pixel-stream source: H32/H40 raster timing (hblank, vblank,
//                hs, vs, frame_start) plus registered test-pattern RGB. All
//                state advances only on pix_ce; mode and pattern are latched
//                at the frame wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H40_ACT = c_H40_ACT,
    parameter int H40_TOT = c_H40_TOT,
    parameter int H32_ACT = c_H32_ACT,
    parameter int H32_TOT = c_H32_TOT,
    parameter int H_FP    = c_H_FP,
    parameter int H_SYNC  = c_H_SYNC,
    parameter int V_ACT   = c_V_ACT,
    parameter int V_TOT   = c_V_TOT,
    parameter int V_FP    = c_V_FP,
    parameter int V_SYNC  = c_V_SYNC
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic       h40,
    input  logic [1:0] pattern,
    output logic       hblank,
    output logic       vblank,
    output logic       hs,
    output logic       vs,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_start
);

    // Counter widths; vcount keeps at least 4 bits for the grid pattern.
    localparam int c_HTOT_MAX = (H40_TOT > H32_TOT) ? H40_TOT : H32_TOT;
    localparam int c_HW       = $clog2(c_HTOT_MAX);
    localparam int c_VW_RAW   = $clog2(V_TOT);
    localparam int c_VW       = (c_VW_RAW < 4) ? 4 : c_VW_RAW;

    // Sized decode thresholds for each mode
    localparam logic [c_HW-1:0] c_H40_ACT_W  = c_HW'(H40_ACT);
    localparam logic [c_HW-1:0] c_H40_LAST_W = c_HW'(H40_TOT - 1);
    localparam logic [c_HW-1:0] c_H40_HSB_W  = c_HW'(H40_ACT + H_FP);
    localparam logic [c_HW-1:0] c_H40_HSE_W  = c_HW'(H40_ACT + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_H40_BAR_W  = c_HW'(bar_width(H40_ACT) - 1);
    localparam logic [c_HW-1:0] c_H32_ACT_W  = c_HW'(H32_ACT);
    localparam logic [c_HW-1:0] c_H32_LAST_W = c_HW'(H32_TOT - 1);
    localparam logic [c_HW-1:0] c_H32_HSB_W  = c_HW'(H32_ACT + H_FP);
    localparam logic [c_HW-1:0] c_H32_HSE_W  = c_HW'(H32_ACT + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_H32_BAR_W  = c_HW'(bar_width(H32_ACT) - 1);

    localparam logic [c_VW-1:0] c_V_ACT_W    = c_VW'(V_ACT);
    localparam logic [c_VW-1:0] c_V_LAST_W   = c_VW'(V_TOT - 1);
    localparam logic [c_VW-1:0] c_VSB_W      = c_VW'(V_ACT + V_FP);
    localparam logic [c_VW-1:0] c_VSE_W      = c_VW'(V_ACT + V_FP + V_SYNC);

    // Raster state
    logic [c_HW-1:0] r_hcount;
    logic [c_VW-1:0] r_vcount;
    logic            r_mode;       // 1 = H40, 0 = H32
    pattern_e        r_pat;
    logic [c_HW-1:0] r_bar_cnt;    // pixel position within the current bar
    logic [2:0]      r_bar_idx;

    // Registered outputs
    logic            r_hblank;
    logic            r_vblank;
    logic            r_hs;
    logic            r_vs;
    logic            r_frame_start;
    rgb24_t          r_rgb;

    // Mode-dependent geometry and decode of the current counters
    logic [c_HW-1:0] w_hact;
    logic [c_HW-1:0] w_hlast;
    logic [c_HW-1:0] w_hs_beg;
    logic [c_HW-1:0] w_hs_end;
    logic [c_HW-1:0] w_bar_last;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_frame_wrap;
    logic            w_hblank;
    logic            w_vblank;
    logic            w_hs;
    logic            w_vs;
    logic            w_frame_start;
    rgb24_t          w_pat_rgb;

    // Geometry follows the latched mode, never the live h40 input.
    always_comb begin
        w_hact        = r_mode ? c_H40_ACT_W  : c_H32_ACT_W;
        w_hlast       = r_mode ? c_H40_LAST_W : c_H32_LAST_W;
        w_hs_beg      = r_mode ? c_H40_HSB_W  : c_H32_HSB_W;
        w_hs_end      = r_mode ? c_H40_HSE_W  : c_H32_HSE_W;
        w_bar_last    = r_mode ? c_H40_BAR_W  : c_H32_BAR_W;
        w_h_wrap      = (r_hcount == w_hlast);
        w_v_wrap      = (r_vcount == c_V_LAST_W);
        w_frame_wrap  = w_h_wrap && w_v_wrap;
        w_hblank      = (r_hcount >= w_hact);
        w_vblank      = (r_vcount >= c_V_ACT_W);
        w_hs          = (r_hcount >= w_hs_beg) && (r_hcount < w_hs_end);
        w_vs          = (r_vcount >= c_VSB_W) && (r_vcount < c_VSE_W);
        w_frame_start = (r_hcount == '0) && (r_vcount == '0);
    end

    // Raster counters; mode and pattern are only taken on the frame wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_mode   <= 1'b1;
            r_pat    <= PAT_BARS;
        end else if (pix_ce) begin
            if (w_h_wrap) begin
                r_hcount <= '0;
                r_vcount <= w_v_wrap ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
            if (w_frame_wrap) begin
                r_mode <= h40;
                r_pat  <= pattern_e'(pattern);
            end
        end
    end

    // Bar tracker stays aligned with hcount so the bar index needs no divider.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
        end else if (pix_ce) begin
            if (w_h_wrap) begin
                r_bar_cnt <= '0;
                r_bar_idx <= 3'd0;
            end else if (r_bar_cnt == w_bar_last) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + 1'b1;
            end
        end
    end

    video_pattern u_pattern (
        .i_pat     (r_pat),
        .i_hlow    (r_hcount[7:0]),
        .i_vlow    (r_vcount[3:0]),
        .i_bar_idx (r_bar_idx),
        .o_rgb     (w_pat_rgb)
    );

    // Output stage: one pix_ce behind the counters, colour blanked outside active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= c_RGB_BLACK;
        end else if (pix_ce) begin
            r_hblank      <= w_hblank;
            r_vblank      <= w_vblank;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_frame_start <= w_frame_start;
            r_rgb         <= (w_hblank || w_vblank) ? c_RGB_BLACK : w_pat_rgb;
        end
    end

    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;
    assign red         = r_rgb.r;
    assign green       = r_rgb.g;
    assign blue        = r_rgb.b;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen. A pixel-level
//                reference model is compared every cycle; directed scenarios
//                pin line/frame lengths, sync placement and pattern pixels.
//                Vertical geometry is shortened to keep full frames cheap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int TB_H_FP   = 14;
    localparam int TB_H_SYNC = 32;
    localparam int TB_V_ACT  = 20;
    localparam int TB_V_TOT  = 26;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;

    logic       clk;
    logic       reset_n;
    logic       pix_ce;
    logic       h40;
    logic [1:0] pattern;
    logic       hblank, vblank, hs, vs, frame_start;
    logic [7:0] red, green, blue;
    logic [28:0] dut_out;

    video_timing_gen #(
        .V_ACT  (TB_V_ACT),
        .V_TOT  (TB_V_TOT),
        .V_FP   (TB_V_FP),
        .V_SYNC (TB_V_SYNC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .h40         (h40),
        .pattern     (pattern),
        .hblank      (hblank),
        .vblank      (vblank),
        .hs          (hs),
        .vs          (vs),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    assign dut_out = {hblank, vblank, hs, vs, red, green, blue, frame_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // ---------------- reference model ----------------
    int          m_h, m_v;
    bit          m_mode;
    logic [1:0]  m_pat;
    logic [28:0] e_out;

    function automatic int htot(input bit mode);
        return mode ? 420 : 342;
    endfunction

    // Expected pins for a given raster position, straight from the pixel rules.
    function automatic logic [28:0] expect_out(input bit mode, input logic [1:0] pat,
                                               input int h, input int v);
        int hact, b;
        bit hb, vb, hsx, vsx, fs;
        logic [23:0] rgb;
        hact = mode ? 320 : 256;
        hb   = (h >= hact);
        vb   = (v >= TB_V_ACT);
        hsx  = (h >= hact + TB_H_FP) && (h < hact + TB_H_FP + TB_H_SYNC);
        vsx  = (v >= TB_V_ACT + TB_V_FP) && (v < TB_V_ACT + TB_V_FP + TB_V_SYNC);
        fs   = (h == 0) && (v == 0);
        rgb  = 24'h0;
        if (!hb && !vb) begin
            case (pat)
                2'd0: begin
                    b = h / (hact / 8);
                    rgb[23:16] = ((b / 2) % 2 == 0) ? 8'hFF : 8'h00;
                    rgb[15:8]  = ((b / 4) % 2 == 0) ? 8'hFF : 8'h00;
                    rgb[7:0]   = (b % 2 == 0)       ? 8'hFF : 8'h00;
                end
                2'd1:    rgb = (h % 2 == 0) ? 24'hFFFFFF : 24'h000000;
                2'd2:    rgb = {8'(h % 256), 16'h0000};
                default: rgb = ((h % 16 == 0) || (v % 16 == 0)) ? 24'hFFFFFF : 24'h202020;
            endcase
        end
        return {hb, vb, hsx, vsx, rgb, fs};
    endfunction

    // Model advances one pixel per pix_ce; pins show the pixel just passed.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_h    <= 0;
            m_v    <= 0;
            m_mode <= 1'b1;
            m_pat  <= 2'd0;
            e_out  <= {1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0};
        end else if (pix_ce) begin
            e_out <= expect_out(m_mode, m_pat, m_h, m_v);
            if (m_h == htot(m_mode) - 1) begin
                m_h <= 0;
                if (m_v == TB_V_TOT - 1) begin
                    m_v    <= 0;
                    m_mode <= h40;
                    m_pat  <= pattern;
                end else begin
                    m_v <= m_v + 1;
                end
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_out !== e_out) begin
                errors++;
                $display("FAIL model t=%0t got %h expected %h", $time, dut_out, e_out);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    int          clk_n = 0;
    bit          prev_hb = 0, prev_fs = 0;
    int          last_fall = -1, last_fs = -1, fs_n = 0, hold_bad = 0;
    int          lens[$];
    int          fs_gap[$];
    logic [28:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit ce);
        logic [28:0] now;
        pix_ce = ce;
        @(posedge clk);
        #2;
        clk_n++;
        now = dut_out;
        if (!ce && reset_n && (now !== prev_out)) hold_bad++;
        prev_out = now;
        if (prev_hb && !hblank) begin
            if (last_fall >= 0) lens.push_back(clk_n - last_fall);
            last_fall = clk_n;
        end
        prev_hb = hblank;
        if (frame_start && !prev_fs) begin
            if (last_fs >= 0) fs_gap.push_back(clk_n - last_fs);
            last_fs = clk_n;
            fs_n++;
        end
        prev_fs = frame_start;
    endtask

    task automatic pixel(input bit slow);
        step(1'b1);
        if (slow) repeat (3) step(1'b0);
    endtask

    task automatic run_to_frame(input int budget, input string name);
        int start;
        bit seen;
        start = fs_n;
        seen  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            pixel(1'b0);
            if (fs_n != start) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    function automatic int count_not(input int want);
        int bad = 0;
        foreach (lens[i]) if (lens[i] != want) bad++;
        return bad;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        int first_hb, hs_start, hs_len, trans;
        logic [23:0] rgbv, prev_rgb;

        reset_n = 1'b0; pix_ce = 1'b0; h40 = 1'b1; pattern = 2'd0;
        step(1'b0);
        chk_en = 1;
        chk("reset_state", dut_out, {1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0});
        step(1'b1);
        chk("reset_beats_ce", dut_out, {1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0});

        // Frame 1: H40 colour bars, pix_ce every clock, line 0 measured.
        reset_n = 1'b1;
        first_hb = -1; hs_start = -1; hs_len = 0; trans = 0; prev_rgb = '0;
        for (int p = 0; p < 420; p++) begin
            pixel(1'b0);
            rgbv = {red, green, blue};
            if (p == 0) begin
                chk("fs_first_pixel", frame_start, 1);
                chk("bar_px0", rgbv, 24'hFFFFFF);
            end
            if (p == 39)  chk("bar_px39",  rgbv, 24'hFFFFFF);
            if (p == 40)  chk("bar_px40",  rgbv, 24'hFFFF00);
            if (p == 45)  chk("bar_px45",  rgbv, 24'hFFFF00);
            if (p == 80)  chk("bar_px80",  rgbv, 24'h00FFFF);
            if (p == 239) chk("bar_px239", rgbv, 24'hFF0000);
            if (p == 240) chk("bar_px240", rgbv, 24'h0000FF);
            if (p == 280) chk("bar_px280", rgbv, 24'h000000);
            if (p == 319) chk("bar_px319", rgbv, 24'h000000);
            if (p > 0 && p < 320 && rgbv != prev_rgb) trans++;
            prev_rgb = rgbv;
            if (hblank && first_hb < 0) first_hb = p;
            if (hs) begin
                if (hs_start < 0) hs_start = p;
                hs_len++;
            end
        end
        chk("h40_hblank_rise", first_hb, 320);
        chk("h40_hs_start",    hs_start, 334);
        chk("h40_hs_width",    hs_len,   32);
        chk("bar_transitions", trans,    7);
        pixel(1'b0);
        chk("h40_line_len", (lens.size() > 0) ? lens[0] : 0, 420);

        // Mid-frame mode/pattern request at vcount=10: must wait for the wrap.
        repeat (10 * 420 - 421) pixel(1'b0);
        h40 = 1'b0; pattern = 2'd1;
        lens.delete();
        run_to_frame(26 * 420, "frame2_reached");
        chk("h40_tail_lines_n",   lens.size(), 17);
        chk("h40_tail_lines_bad", count_not(420), 0);
        chk("frame1_clks", (fs_gap.size() > 0) ? fs_gap[0] : 0, 10920);

        // Frame 2: H32 stripe.
        chk("stripe_px0", {red, green, blue}, 24'hFFFFFF);
        first_hb = -1; hs_start = -1;
        for (int p = 1; p < 342; p++) begin
            pixel(1'b0);
            rgbv = {red, green, blue};
            if (p == 1)   chk("stripe_px1",   rgbv, 24'h000000);
            if (p == 254) chk("stripe_px254", rgbv, 24'hFFFFFF);
            if (p == 255) chk("stripe_px255", rgbv, 24'h000000);
            if (p == 256) chk("stripe_px256", {hblank, rgbv}, {1'b1, 24'h000000});
            if (hblank && first_hb < 0) first_hb = p;
            if (hs && hs_start < 0) hs_start = p;
        end
        chk("h32_hblank_rise", first_hb, 256);
        chk("h32_hs_start",    hs_start, 270);
        h40 = 1'b1; pattern = 2'd3;
        lens.delete();
        run_to_frame(26 * 342, "frame3_reached");
        chk("h32_lines_n",   lens.size(), 26);
        chk("h32_lines_bad", count_not(342), 0);
        chk("frame2_clks", (fs_gap.size() > 1) ? fs_gap[1] : 0, 8892);

        // Frame 3: H40 grid with pix_ce one clock in four.
        chk("grid_px0", {red, green, blue}, 24'hFFFFFF);
        lens.delete();
        hold_bad = 0;
        for (int p = 1; p < 420; p++) begin
            pixel(1'b1);
            if (p == 5) chk("grid_l0_px5", {red, green, blue}, 24'hFFFFFF);
        end
        for (int p = 0; p < 420; p++) begin
            pixel(1'b1);
            rgbv = {red, green, blue};
            if (p == 0)  chk("grid_l1_px0",  rgbv, 24'hFFFFFF);
            if (p == 1)  chk("grid_l1_px1",  rgbv, 24'h202020);
            if (p == 16) chk("grid_l1_px16", rgbv, 24'hFFFFFF);
            if (p == 17) chk("grid_l1_px17", rgbv, 24'h202020);
        end
        pixel(1'b1);
        chk("slow_line_clks", (lens.size() > 1) ? lens[1] : 0, 1680);

        // Mid-line reset at hcount=150, vcount=5.
        for (int i = 0; i < 5 * 420 && !(m_h == 150 && m_v == 5); i++) pixel(1'b1);
        chk("reach_h150_v5", (m_h == 150 && m_v == 5), 1);
        reset_n = 1'b0; pix_ce = 1'b1;
        @(posedge clk);
        #2;
        chk("midline_reset", dut_out, {1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0});
        reset_n = 1'b1;
        step(1'b1);
        chk("fs_after_release", frame_start, 1);
        chk("px0_after_release", {red, green, blue}, 24'hFFFFFF);
        repeat (4) pixel(1'b1);
        chk("hold_without_ce", hold_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-stream source for the video output path: generates hblank/vblank/hs/vs and test-pattern RGB, advancing only on pix_ce.
- Output contract matches what the horizontal-blend post-filter consumes; feeds it directly for bring-up and filter verification.
- Two horizontal modes, H32 (256 active) and H40 (320 active), switched only at frame boundaries.

Parameters:
- H40_ACT, 320, active pixels per line in H40 mode (multiple of 8)
- H40_TOT, 420, total pixels per line in H40 mode
- H32_ACT, 256, active pixels per line in H32 mode (multiple of 8)
- H32_TOT, 342, total pixels per line in H32 mode
- H_FP, 14, front-porch pixels after active, both modes
- H_SYNC, 32, hs width in pixels, both modes
- V_ACT, 224, active lines
- V_TOT, 262, total lines
- V_FP, 3, front-porch lines
- V_SYNC, 3, vs width in lines

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- h40  in  1  requested mode, 1=H40, 0=H32; sampled at frame wrap
- pattern  in  2  0=colour bars, 1=alternating pixel stripe, 2=red gradient, 3=grid; sampled at frame wrap
- hblank  out  1  horizontal blank
- vblank  out  1  vertical blank
- hs  out  1  horizontal sync, active high
- vs  out  1  vertical sync, active high
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel
- frame_start  out  1  one-pix_ce pulse on first active pixel of a frame

Behaviour:
- Reset (reset_n=0 at clk edge, regardless of pix_ce): hcount=0, vcount=0, mode_q=1 (H40), pat_q=0, hblank=1, vblank=1, hs=0, vs=0, rgb=0, frame_start=0. Reset wins over pix_ce in the same cycle.
- Counters: hcount 0..HTOT-1, vcount 0..V_TOT-1. HTOT/HACT are taken from mode_q.
- On pix_ce, hcount increments. At HTOT-1 it wraps to 0 and vcount increments; vcount wraps at V_TOT-1.
- Frame wrap: the pix_ce where hcount=HTOT-1 and vcount=V_TOT-1. On that pix_ce, mode_q<=h40 and pat_q<=pattern. Changes at any other time have no effect until the next frame wrap.
- Outputs are registered and update only on pix_ce. They reflect the pre-increment counters, so latency from counter to pins is one pix_ce.
- Output decode:
  - hblank = hcount>=HACT
  - hs = hcount in [HACT+H_FP, HACT+H_FP+H_SYNC)
  - vblank = vcount>=V_ACT
  - vs = vcount in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC)
  - frame_start = hcount==0 && vcount==0
- RGB is forced to 0 whenever hblank or vblank is set.
- Colour bars:
  - Bar index b = 0..7; bar width is HACT/8 (40 in H40, 32 in H32).
  - Track b with a bar sub-counter that resets at hcount=0; no divider.
  - red=FF if b[1]==0, green=FF if b[2]==0, blue=FF if b[0]==0, else 00.
  - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
- Stripe: hcount[0]==0 gives FFFFFF, odd pixel gives 000000.
- Gradient: red=hcount[7:0], green=blue=0.
- Grid: FFFFFF when hcount[3:0]==0 or vcount[3:0]==0, else 202020.
- No pix_ce: all outputs hold.

Decomposition:
- Shared package video_pkg:
  - pattern enum (PAT_BARS, PAT_STRIPE, PAT_GRAD, PAT_GRID)
  - mode constants H40/H32 ACT/TOT
  - typedef for the rgb24 struct
- Sub-module video_pattern: combinational RGB from (pat_q, hcount, vcount, bar index), registered in the parent.

Test Plan:
- Reset with h40=1, pix_ce held 1, count one line:
  - hblank first rises after 320 pix_ce.
  - hs high for exactly 32 pix_ce, starting 334 pix_ce into the line.
  - Line length is 420.
- Change h40 1->0 mid-frame (vcount=100):
  - Remaining lines stay at 420.
  - After frame wrap, lines are 342 with 256 active; frame_start pulses exactly once per 262 lines.
- pattern=0, H40: bar transitions after 40, 80, ..., 280 active pixels.
  - First pixel FFFFFF; pixel 45 = FFFF00; pixel 319 = 000000.
- pattern=1:
  - Active pixels alternate FFFFFF/000000.
  - Pixel 320 onward is 0 with hblank=1.
- pix_ce toggling 1-of-4 cycles: outputs change only on pix_ce edges; line length is 420×4 clk.
- Assert reset_n=0 mid-line at hcount=150, vcount=50:
  - Next clk: hcount=0, hblank=1, rgb=0.
  - After release, first frame_start occurs after 1 pix_ce.
